data_pack: RTL
==============

DATA_PACK -- requirements
Module: data_pack

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous assert, active-low, synchronous deassert by system.
REQ-003 SHALL have port: pkt_in  input  7  packet to pack; bit 0 is the first bit in the stream.
REQ-004 SHALL have port: pkt_valid  input  1  pkt_in is valid this cycle.
REQ-005 SHALL have port: pkt_ready  output  1  block accepts pkt_in this cycle; a packet transfers when pkt_valid & pkt_ready.
REQ-006 SHALL have port: flush  input  1  level request to emit the partial word, zero-padded.
REQ-007 SHALL have port: word_out  output  32  packed word.
REQ-008 SHALL have port: word_valid  output  1  word_out is valid; a word transfers when word_valid & word_ready.
REQ-009 SHALL have port: word_ready  input  1  downstream accepts word_out.
REQ-010 SHALL have port: word_last  output  1  qualifies word_out as a flushed (padded) word.
REQ-011 SHALL have port: fill  output  5  count of valid bits held in the accumulator, 0..31.
REQ-012 SHALL have port: flush_done  output  1  one-cycle pulse when a flush completes.

Function
REQ-013 SHALL pack packets as a continuous LSB-first bitstream: the packet accepted at fill=f occupies stream bits f..f+6 of the current word.
REQ-014 SHALL, when f+7 < 32, place the packet in bits [f+6:f] and set fill to f+7.
REQ-015 SHALL, when f+7 >= 32, complete the word with packet bits [31-f:0] in word bits [31:f], load it into the output register, and keep packet bits [6:32-f] as the low bits of the next word, with fill = f+7-32 (0..6).
REQ-016 SHALL assert word_valid in the cycle after the completing packet handshake (latency 1), with word_out stable until the word transfers.
REQ-017 SHALL drive pkt_ready = !flush & (!word_valid | word_ready), so no word can be lost under backpressure.
REQ-018 SHALL, while flush is high and fill > 0, wait until the output register is free (!word_valid | word_ready), then emit the accumulator zero-padded to 32 bits with word_last=1, clear fill to 0, and pulse flush_done in the same cycle the padded word is loaded.
REQ-019 SHALL, when flush is high and fill = 0, pulse flush_done once without emitting a word.
REQ-020 SHALL pulse flush_done once per flush request; flush_done SHALL stay low until flush has deasserted and been reasserted.
REQ-021 SHALL keep word_last=0 for words completed by REQ-015.
REQ-022 SHALL do 5-bit fill arithmetic modulo 32, with the wrap condition detected from the 6-bit sum f+7.
REQ-023 SHALL allow a word transfer and a packet acceptance in the same cycle (full throughput: one packet per cycle).

Reset
REQ-024 SHALL, on rst_n low, immediately clear: accumulator, fill=0, word_out=0, word_valid=0, word_last=0, flush_done=0.
REQ-025 SHALL, when reset occurs mid-word, discard the partial word and any pending output word.

Structure
REQ-026 SHALL take constants PKT_W=7, WORD_W=32, FILL_W=5 from shared package data_pack_pkg; the unpacker SHALL use the same package.
REQ-027 SHALL contain one sub-module, data_pack_outreg: a 32+1-bit valid/ready output register holding word_out and word_last.

Verification
REQ-028 SHALL test: packets 0x01,0x02,0x03,0x04,0x05 back-to-back with word_ready=1 -> one word 0x5080C101, word_last=0, then fill=3.
REQ-029 SHALL test: after REQ-028, flush=1 -> word 0x00000000, word_last=1, flush_done pulse, fill=0.
REQ-030 SHALL test: 32 packets of 0x7F with word_ready=0 after the first word -> pkt_ready low after the next completing packet, no packet dropped, and all 7 words equal 0xFFFFFFFF once ready is released.
REQ-031 SHALL test: flush with fill=0 -> flush_done pulse, no word_valid.
REQ-032 SHALL test: rst_n low while fill=20 and word_valid=1 -> all outputs 0 immediately; the next 5 packets of 0x7F produce 0xFFFFFFFF.
REQ-033 SHALL test: a loopback of data_pack into data_unpack with 1000 random packets -> identical packet sequence out.

Source files
------------

// File: rtl/data_pack_pkg.sv
// Shared constants and types for the 7-bit packet packer and its matching unpacker.
package data_pack_pkg;
  localparam int PKT_W  = 7;
  localparam int WORD_W = 32;
  localparam int FILL_W = 5;

  typedef struct packed {
    logic              last;
    logic [WORD_W-1:0] data;
  } word_t;

  typedef enum logic {
    FL_IDLE,
    FL_DONE
  } flush_st_t;
endpackage

// File: rtl/data_pack_outreg.sv
// Valid/ready output register for packed words; a load always wins over a drain.
module data_pack_outreg
  import data_pack_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  load,
  input  word_t load_word,
  input  logic  ready,
  output word_t word,
  output logic  valid
);
  // The parent only loads when the register is empty or draining this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word  <= '0;
      valid <= 1'b0;
    end else if (load) begin
      word  <= load_word;
      valid <= 1'b1;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/data_unpack.sv
// Splits a stream of 32-bit words back into 7-bit packets, LSB first.
module data_unpack
  import data_pack_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic [PKT_W-1:0]  pkt_out,
  output logic              pkt_valid
);
  localparam int BUF_W = WORD_W + PKT_W;
  localparam int CNT_W = 6;

  logic [BUF_W-1:0] bits;
  logic [CNT_W-1:0] cnt;

  // A new word is taken only once fewer than one packet's worth of bits remain.
  assign word_ready = cnt < CNT_W'(PKT_W);
  assign pkt_valid  = !word_ready;
  assign pkt_out    = bits[PKT_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bits <= '0;
      cnt  <= '0;
    end else if (word_valid && word_ready) begin
      bits <= bits | ({{PKT_W{1'b0}}, word_in} << cnt);
      cnt  <= cnt + CNT_W'(WORD_W);
    end else if (pkt_valid) begin
      bits <= bits >> PKT_W;
      cnt  <= cnt - CNT_W'(PKT_W);
    end
  end
endmodule

// File: rtl/data_pack.sv
// Packs 7-bit packets into a continuous LSB-first stream of 32-bit words, with
// a level-sensitive flush that emits the partial word zero-padded.
module data_pack
  import data_pack_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PKT_W-1:0]  pkt_in,
  input  logic              pkt_valid,
  output logic              pkt_ready,
  input  logic              flush,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              word_last,
  output logic [FILL_W-1:0] fill,
  output logic              flush_done
);
  logic [WORD_W-1:0]       acc;
  logic [WORD_W+PKT_W-1:0] shifted;
  logic [FILL_W:0]         sum;
  logic                    out_free, accept, wrap, flush_load, flush_fire;
  flush_st_t               fl_st, fl_nxt;
  word_t                   load_word, out_word;

  assign out_free  = !word_valid || word_ready;
  assign pkt_ready = !flush && out_free;
  assign accept    = pkt_valid && pkt_ready;
  assign sum       = {1'b0, fill} + (FILL_W+1)'(PKT_W);
  assign wrap      = sum[FILL_W];
  // Upper PKT_W bits hold whatever spills past bit 31 into the next word.
  assign shifted   = {{WORD_W{1'b0}}, pkt_in} << fill;

  always_comb begin
    fl_nxt     = fl_st;
    flush_load = 1'b0;
    flush_fire = 1'b0;
    case (fl_st)
      FL_IDLE: if (flush) begin
        if (fill == '0) begin
          flush_fire = 1'b1;
          fl_nxt     = FL_DONE;
        end else if (out_free) begin
          flush_load = 1'b1;
          flush_fire = 1'b1;
          fl_nxt     = FL_DONE;
        end
      end
      FL_DONE: if (!flush) fl_nxt = FL_IDLE;
      default: fl_nxt = FL_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      fill       <= '0;
      fl_st      <= FL_IDLE;
      flush_done <= 1'b0;
    end else begin
      fl_st      <= fl_nxt;
      flush_done <= flush_fire;
      if (flush_load) begin
        acc  <= '0;
        fill <= '0;
      end else if (accept) begin
        acc  <= wrap ? {{(WORD_W-PKT_W){1'b0}}, shifted[WORD_W +: PKT_W]}
                     : (acc | shifted[WORD_W-1:0]);
        fill <= sum[FILL_W-1:0];
      end
    end
  end

  assign load_word.data = flush_load ? acc : (acc | shifted[WORD_W-1:0]);
  assign load_word.last = flush_load;

  data_pack_outreg u_outreg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      ((accept && wrap) || flush_load),
    .load_word (load_word),
    .ready     (word_ready),
    .word      (out_word),
    .valid     (word_valid)
  );

  assign word_out  = out_word.data;
  assign word_last = out_word.last;
endmodule
